// File: rtl/mp3_sched_pkg.sv
// Shared constants for the requantizer scheduler: FSM encoding, slot indices
// and the slot-to-done-bit mapping used by the Huffman/scalefactor handshake.
package mp3_sched_pkg;

    localparam int NUM_SAMPLES = 576;
    localparam int ADDR_W      = 10;

    localparam logic [1:0] SLOT_00 = 2'b00;
    localparam logic [1:0] SLOT_01 = 2'b01;
    localparam logic [1:0] SLOT_10 = 2'b10;
    localparam logic [1:0] SLOT_11 = 2'b11;

    typedef logic [1:0] sched_state_t;
    localparam sched_state_t ST_IDLE   = 2'd0;
    localparam sched_state_t ST_WAIT   = 2'd1;
    localparam sched_state_t ST_STREAM = 2'd2;
    localparam sched_state_t ST_NEXT   = 2'd3;

    // Done vectors are MSB-first: bit3 is (gr0,ch0), bit0 is (gr1,ch1).
    function automatic logic [1:0] slot_to_bit(input logic [1:0] slot);
        return 2'd3 - slot;
    endfunction

endpackage

// File: rtl/sched_skid_fifo.sv
// Small circular skid buffer holding BRAM returns until the requantizer takes
// them; flush drops everything at once.
module sched_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0) && !flush;
    assign do_push = push && !flush && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/requant_scheduler.sv
// Streams the four per-(granule,channel) Huffman sample BRAMs of a frame into the
// shared requantizer, one slot at a time, once each slot is fully decoded.
module requant_scheduler
    import mp3_sched_pkg::*;
#(
    parameter int NUM_SAMPLES = mp3_sched_pkg::NUM_SAMPLES,
    parameter int BRAM_LAT    = 2,
    parameter int SKID_DEPTH  = 4,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              si_valid,
    input  logic              mono,
    input  logic [3:0]        hf_done,
    input  logic [3:0]        sf_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_sel,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_pos,
    output logic              out_gr,
    output logic              out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              slot_done,
    output logic              frame_done,
    output logic              busy,
    output logic              overrun
);
    localparam int ENT_W = DATA_W + ADDR_W + 2;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W = $clog2(SKID_DEPTH + BRAM_LAT + 1) + 1;
    localparam logic [ADDR_W-1:0] LAST_POS = ADDR_W'(NUM_SAMPLES - 1);

    sched_state_t      state;
    logic [1:0]        slot;
    logic              mono_q;
    logic              issued_all;
    logic [3:0]        hf_flag;
    logic [3:0]        sf_flag;
    logic [3:0]        hf_seen;
    logic [3:0]        sf_seen;
    logic [1:0]        cur_bit;
    logic [BRAM_LAT-1:0] vld_p;
    logic [ADDR_W-1:0] pos_p [BRAM_LAT];
    logic [1:0]        sel_p [BRAM_LAT];
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  skid_count;
    logic [ENT_W-1:0]  skid_head;
    logic              push;
    logic              pop;
    logic              abort;
    logic              last_accept;

    // Reads in flight plus buffered samples bound total occupancy, so the skid never overflows.
    always_comb begin
        occ = OCC_W'(skid_count);
        for (int i = 0; i < BRAM_LAT; i++) occ = occ + OCC_W'(vld_p[i]);
    end

    assign busy        = (state != ST_IDLE);
    assign abort       = si_valid && busy;
    assign rd_en       = (state == ST_STREAM) && !issued_all && (occ < OCC_W'(SKID_DEPTH));
    assign rd_sel      = slot;
    assign push        = vld_p[BRAM_LAT-1] && !abort;
    assign out_valid   = (skid_count != '0);
    assign pop         = out_valid && out_ready;
    assign {out_data, out_pos, out_gr, out_ch} = skid_head;
    assign last_accept = pop && (out_pos == LAST_POS);
    assign hf_seen     = hf_flag | hf_done;
    assign sf_seen     = sf_flag | sf_done;
    assign cur_bit     = slot_to_bit(slot);

    sched_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (ENT_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({rd_data, pos_p[BRAM_LAT-1], sel_p[BRAM_LAT-1]}),
        .pop       (pop),
        .flush     (abort),
        .head      (skid_head),
        .count     (skid_count)
    );

    // Stage boundary: read-tag pipeline, aligned with the BRAM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (si_valid) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= rd_en;
            for (int i = 1; i < BRAM_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pos_p[0] <= rd_addr;
        sel_p[0] <= slot;
        for (int i = 1; i < BRAM_LAT; i++) begin
            pos_p[i] <= pos_p[i-1];
            sel_p[i] <= sel_p[i-1];
        end
    end

    // A new frame discards old flags, but a done pulse in the same cycle still lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hf_flag <= '0;
            sf_flag <= '0;
        end else if (si_valid) begin
            hf_flag <= hf_done;
            sf_flag <= sf_done;
        end else begin
            hf_flag <= hf_seen;
            sf_flag <= sf_seen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            slot       <= SLOT_00;
            mono_q     <= 1'b0;
            rd_addr    <= '0;
            issued_all <= 1'b0;
            slot_done  <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            slot_done  <= 1'b0;
            frame_done <= 1'b0;
            if (si_valid) begin
                if (busy) overrun <= 1'b1;
                mono_q     <= mono;
                slot       <= SLOT_00;
                rd_addr    <= '0;
                issued_all <= 1'b0;
                state      <= ST_WAIT;
            end else begin
                case (state)
                    ST_WAIT: begin
                        if (hf_seen[cur_bit] && sf_seen[cur_bit]) begin
                            rd_addr    <= '0;
                            issued_all <= 1'b0;
                            state      <= ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (rd_en) begin
                            if (rd_addr == LAST_POS) issued_all <= 1'b1;
                            else                     rd_addr    <= rd_addr + 1'b1;
                        end
                        if (last_accept) begin
                            slot_done <= 1'b1;
                            state     <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if ((slot == SLOT_11) || (mono_q && (slot == SLOT_10))) begin
                            frame_done <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            slot  <= mono_q ? slot + 2'd2 : slot + 2'd1;
                            state <= ST_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_requant_scheduler.sv
// Directed bench for requant_scheduler: frame scenarios from a table plus
// hand-written latency, overrun and mid-stream reset sequences.
module tb_requant_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        si_valid;
    logic        mono;
    logic [3:0]  hf_done;
    logic [3:0]  sf_done;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_sel;
    logic [15:0] rd_data;
    logic [15:0] out_data;
    logic [9:0]  out_pos;
    logic        out_gr;
    logic        out_ch;
    logic        out_valid;
    logic        out_ready;
    logic        slot_done;
    logic        frame_done;
    logic        busy;
    logic        overrun;

    requant_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .si_valid   (si_valid),
        .mono       (mono),
        .hf_done    (hf_done),
        .sf_done    (sf_done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .out_data   (out_data),
        .out_pos    (out_pos),
        .out_gr     (out_gr),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .slot_done  (slot_done),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bram_word(input logic [1:0] s, input logic [9:0] a);
        return {s, 4'b1010, a};
    endfunction

    // Two-cycle BRAM model holding a recognisable pattern per slot/address
    logic [15:0] bram_d1;
    logic [15:0] bram_d2;
    always @(posedge clk) begin
        bram_d1 <= bram_word(rd_sel, rd_addr);
        bram_d2 <= bram_d1;
    end
    assign rd_data = bram_d2;

    typedef struct {
        logic pre;
        logic mono;
        int   duty;
        logic split;
        int   exp_samples;
        int   exp_sd;
    } frame_vec_t;

    frame_vec_t  vecs [5];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    logic        mon_en;
    logic        mon_mono;
    logic [1:0]  exp_slot;
    int          exp_pos;
    int          accepted;
    int          reads;
    int          outstanding;
    int          sd_cnt;
    int          fd_cnt;
    int          sd_at_fd;
    int          first_rd;
    int          first_ov;
    logic        stalled;
    logic [28:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_mon(input logic m);
        mon_mono    = m;
        exp_slot    = 2'd0;
        exp_pos     = 0;
        accepted    = 0;
        reads       = 0;
        outstanding = 0;
        sd_cnt      = 0;
        fd_cnt      = 0;
        sd_at_fd    = 0;
        first_rd    = -1;
        first_ov    = -1;
        stalled     = 1'b0;
        held        = '0;
    endtask

    task automatic monitor_step();
        cyc++;
        if (!mon_en) return;
        if (rd_en) begin
            reads++;
            outstanding++;
            if (first_rd < 0) first_rd = cyc;
            check("rd_sel", rd_sel, exp_slot);
            check("rd_addr_max", rd_addr > 10'd575, 1'b0);
            check("occupancy", outstanding > 4, 1'b0);
        end
        if (stalled) check("stall_hold", {out_valid, out_gr, out_ch, out_pos, out_data}, held);
        stalled = out_valid && !out_ready;
        held    = {out_valid, out_gr, out_ch, out_pos, out_data};
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (out_valid && out_ready) begin
            check("sample", {out_gr, out_ch, out_pos, out_data},
                  {exp_slot, exp_pos[9:0], bram_word(exp_slot, exp_pos[9:0])});
            accepted++;
            outstanding--;
            exp_pos++;
            if (exp_pos == 576) begin
                exp_pos  = 0;
                exp_slot = exp_slot + (mon_mono ? 2'd2 : 2'd1);
            end
        end
        if (slot_done) sd_cnt++;
        if (frame_done) begin
            fd_cnt++;
            sd_at_fd = sd_cnt;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic m);
        si_valid = 1'b1;
        mono     = m;
        tick();
        si_valid = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] hf, input logic [3:0] sf);
        hf_done = hf;
        sf_done = sf;
        tick();
        hf_done = 4'd0;
        sf_done = 4'd0;
    endtask

    task automatic wait_frame(input int duty, input int budget);
        int n = 0;
        while (fd_cnt == 0 && n < budget) begin
            out_ready = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
            tick();
            n++;
        end
        out_ready = 1'b1;
        check("frame_timeout", fd_cnt != 0, 1'b1);
    endtask

    initial begin
        logic [3:0] mask;
        int         sf_cyc;
        int         n;

        vecs[0] = '{1'b1, 1'b0, 100, 1'b0, 2304, 4};
        vecs[1] = '{1'b0, 1'b1, 100, 1'b0, 1152, 2};
        vecs[2] = '{1'b0, 1'b0,  30, 1'b0, 2304, 4};
        vecs[3] = '{1'b0, 1'b1,  30, 1'b1, 1152, 2};
        vecs[4] = '{1'b0, 1'b0,  70, 1'b1, 2304, 4};

        rst_n     = 1'b0;
        si_valid  = 1'b0;
        mono      = 1'b0;
        hf_done   = 4'd0;
        sf_done   = 4'd0;
        out_ready = 1'b1;
        mon_en    = 1'b1;
        reset_mon(1'b0);
        repeat (3) tick();
        check("reset_outputs",
              {rd_en, rd_addr, rd_sel, out_data, out_pos, out_gr, out_ch, out_valid,
               slot_done, frame_done, busy, overrun}, 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < 5; v++) begin
            mask = vecs[v].mono ? 4'b1010 : 4'b1111;
            reset_mon(vecs[v].mono);
            if (vecs[v].pre) begin
                pulse(mask, mask);
                start_frame(vecs[v].mono);
                repeat (20) tick();
                check("premask_no_reads", reads, 0);
                check("premask_busy", busy, 1'b1);
            end else begin
                start_frame(vecs[v].mono);
            end
            if (vecs[v].split) begin
                pulse(4'd0, mask);
                repeat (5) tick();
                pulse(mask, 4'd0);
            end else begin
                pulse(mask, mask);
            end
            wait_frame(vecs[v].duty, 20000);
            check("frame_samples", accepted, vecs[v].exp_samples);
            check("slot_done_before_fd", sd_at_fd, vecs[v].exp_sd);
            check("frame_done_count", fd_cnt, 1);
            check("busy_after_frame", busy, 1'b0);
            check("no_overrun", overrun, 1'b0);
            repeat (5) tick();
            check("frame_done_single", fd_cnt, 1);
        end

        // hf arrives long before sf for slot (0,0)
        reset_mon(1'b0);
        start_frame(1'b0);
        pulse(4'b1000, 4'd0);
        repeat (100) tick();
        check("hf_only_no_reads", reads, 0);
        sf_cyc = cyc + 1;
        pulse(4'd0, 4'b1000);
        repeat (10) tick();
        check("stream_after_sf", (first_rd > sf_cyc) && (first_rd <= sf_cyc + 2), 1'b1);
        check("first_valid_latency", first_ov - first_rd, 3);
        pulse(4'b0111, 4'b0111);
        wait_frame(100, 5000);
        check("latency_frame_samples", accepted, 2304);

        // New side info arrives mid-stream of slot (0,1)
        reset_mon(1'b0);
        start_frame(1'b0);
        pulse(4'b1100, 4'b1100);
        n = 0;
        while (!(exp_slot == 2'd1 && exp_pos > 200) && n < 3000) begin
            tick();
            n++;
        end
        check("overrun_reach_pos200", exp_slot == 2'd1 && exp_pos > 200, 1'b1);
        start_frame(1'b0);
        reset_mon(1'b0);
        check("overrun_set", overrun, 1'b1);
        repeat (10) tick();
        check("overrun_no_stale", first_ov < 0, 1'b1);
        check("overrun_no_reads", reads, 0);
        check("overrun_no_slot_done", sd_cnt + fd_cnt, 0);
        pulse(4'hF, 4'hF);
        wait_frame(100, 5000);
        check("overrun_restart_samples", accepted, 2304);
        check("overrun_sticky", overrun, 1'b1);

        // Asynchronous reset in the middle of a stream
        reset_mon(1'b0);
        start_frame(1'b0);
        pulse(4'b1000, 4'b1000);
        n = 0;
        while (accepted < 50 && n < 500) begin
            tick();
            n++;
        end
        check("midreset_reach", accepted >= 50, 1'b1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midreset_outputs",
              {rd_en, rd_addr, rd_sel, out_data, out_pos, out_gr, out_ch, out_valid,
               slot_done, frame_done, busy, overrun}, 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("post_reset_idle", {busy, rd_en, out_valid, overrun}, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
